// File: rtl/z80_host_master_if.sv
// Shared Z80 bus seen by a bus master: CPU-style master outputs, slave
// return path and the BUSRQ/BUSACK arbitration handshake.
interface z80_host_master_if;
   logic [15:0] addr;
   logic [7:0]  dmaster;
   logic        rdn;
   logic        wrn;
   logic        mreqn;
   logic        iorqn;
   logic        inta;
   logic [7:0]  dslave;
   logic        mwait;
   logic        busrq;
   logic        busack;

   // Master drives the cycle and requests the bus; slave side answers.
   modport master (
      output addr, dmaster, rdn, wrn, mreqn, iorqn, inta, busrq,
      input  dslave, mwait, busack
   );

   modport slave (
      input  addr, dmaster, rdn, wrn, mreqn, iorqn, inta, busrq,
      output dslave, mwait, busack
   );
endinterface

// File: rtl/z80_host_master.sv
// Host-driven Z80 bus initiator: takes a burst command from a host, wins the
// bus through BUSRQ/BUSACK and replays CPU-style memory or I/O cycles,
// stretching each cycle while the slave holds mwait low.
module z80_host_master #(
   parameter int WAIT_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic        cmd_io_i,
   input  logic [15:0] cmd_addr_i,
   input  logic [7:0]  cmd_len_i,
   input  logic [7:0]  wdata_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   output logic [7:0]  rdata_o,
   output logic        rvalid_o,
   output logic        done_o,
   output logic        err_o,
   z80_host_master_if.master bus
);

   localparam int CW = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, REQ, WDAT, T1, T2, TW, T3, REL
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   curAddr_q, curAddr_d;
   logic [7:0]    remaining_q, remaining_d;
   logic          we_q, we_d;
   logic          io_q, io_d;
   logic [7:0]    dmaster_q, dmaster_d;
   logic [7:0]    rdata_q, rdata_d;
   logic [CW-1:0] waitCnt_q, waitCnt_d;
   logic          errFlag_q, errFlag_d;
   logic          done_q, done_d;
   logic          errOut_q, errOut_d;
   logic          cmdReady;
   logic          wreadyC;
   logic          rvalidC;
   logic          strobeOn;

   // Next-state and handshake decode; all bus progress is gated by cen except
   // the command and write-data handoffs, which run at clk rate.
   always_comb begin
      state_d     = state_q;
      curAddr_d   = curAddr_q;
      remaining_d = remaining_q;
      we_d        = we_q;
      io_d        = io_q;
      dmaster_d   = dmaster_q;
      rdata_d     = rdata_q;
      waitCnt_d   = waitCnt_q;
      errFlag_d   = errFlag_q;
      done_d      = 1'b0;
      errOut_d    = 1'b0;
      cmdReady    = 1'b0;
      wreadyC     = 1'b0;
      rvalidC     = 1'b0;
      case (state_q)
         IDLE: begin
            cmdReady = 1'b1;
            if (cmd_valid_i) begin
               we_d        = cmd_we_i;
               io_d        = cmd_io_i;
               curAddr_d   = cmd_addr_i;
               remaining_d = cmd_len_i;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (cen_i && bus.busack) begin
               state_d = we_q ? WDAT : T1;
            end
         end
         WDAT: begin
            wreadyC = 1'b1;
            if (wvalid_i) begin
               dmaster_d = wdata_i;
               state_d   = T1;
            end
         end
         T1: begin
            waitCnt_d = '0;
            if (cen_i) begin
               state_d = T2;
            end
         end
         T2: begin
            if (cen_i) begin
               state_d = bus.mwait ? T3 : TW;
            end
         end
         TW: begin
            if (cen_i) begin
               if (bus.mwait) begin
                  state_d = T3;
               end else if (waitCnt_q == CNT_LAST) begin
                  errFlag_d = 1'b1;
                  state_d   = REL;
               end else begin
                  waitCnt_d = waitCnt_q + CNT_ONE;
               end
            end
         end
         T3: begin
            if (cen_i) begin
               if (!we_q) begin
                  rvalidC = 1'b1;
                  rdata_d = bus.dslave;
               end
               if (remaining_q == 8'd0) begin
                  state_d = REL;
               end else begin
                  curAddr_d   = curAddr_q + 16'd1;
                  remaining_d = remaining_q - 8'd1;
                  state_d     = we_q ? WDAT : T1;
               end
            end
         end
         REL: begin
            if (cen_i && !bus.busack) begin
               done_d    = 1'b1;
               errOut_d  = errFlag_q;
               errFlag_d = 1'b0;
               waitCnt_d = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         curAddr_q   <= 16'h0000;
         remaining_q <= 8'h00;
         we_q        <= 1'b0;
         io_q        <= 1'b0;
         dmaster_q   <= 8'h00;
         rdata_q     <= 8'h00;
         waitCnt_q   <= '0;
         errFlag_q   <= 1'b0;
         done_q      <= 1'b0;
         errOut_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         curAddr_q   <= curAddr_d;
         remaining_q <= remaining_d;
         we_q        <= we_d;
         io_q        <= io_d;
         dmaster_q   <= dmaster_d;
         rdata_q     <= rdata_d;
         waitCnt_q   <= waitCnt_d;
         errFlag_q   <= errFlag_d;
         done_q      <= done_d;
         errOut_q    <= errOut_d;
      end
   end

   // Strobes are low only in T2/TW, and the io/we selects make the
   // mreqn/iorqn and rdn/wrn pairs mutually exclusive by construction.
   assign strobeOn    = (state_q == T2) || (state_q == TW);
   assign bus.mreqn   = !(strobeOn && !io_q);
   assign bus.iorqn   = !(strobeOn && io_q);
   assign bus.rdn     = !(strobeOn && !we_q);
   assign bus.wrn     = !(strobeOn && we_q);
   assign bus.inta    = 1'b1;
   assign bus.addr    = curAddr_q;
   assign bus.dmaster = dmaster_q;
   assign bus.busrq   = (state_q != IDLE) && (state_q != REL);

   // Read data is forwarded straight from the slave on the T3 cen so it is
   // valid alongside rvalid, then held from the register until the next read.
   assign cmd_ready_o = cmdReady && rst_n;
   assign wready_o    = wreadyC && rst_n;
   assign rvalid_o    = rvalidC && rst_n;
   assign rdata_o     = rvalid_o ? bus.dslave : rdata_q;
   assign done_o      = done_q;
   assign err_o       = errOut_q;

endmodule

// File: tb/tb_z80_host_master.sv
// Directed bench for z80_host_master: ROM-style slave with programmable wait
// states, BUSACK arbiter with programmable grant delay, and passive bus
// monitors whose counters are compared against hand-computed values.
module tb_z80_host_master;

   logic        clk = 1'b0;
   logic        rstN;
   logic [1:0]  cenDiv = 2'd0;
   logic        cen;
   logic        cmdValid, cmdReady, cmdWe, cmdIo;
   logic [15:0] cmdAddr;
   logic [7:0]  cmdLen, wdata, rdata;
   logic        wvalid, wready, rvalid, done, err;

   int nAsserts = 0;
   int nFail    = 0;

   int ackDelay    = 0;
   int ackCnt      = 0;
   int slaveWaits  = 0;
   int slaveCnt    = 0;

   int wrLowTicks = 0, rdLowTicks = 0, mreqLowTicks = 0, iorqLowTicks = 0;
   int strobeLowTicks = 0, busTicks = 0, reqWaitTicks = 0, wrWindows = 0;
   int ioMemBoth = 0, rdWrBoth = 0, noAckStrobe = 0;
   int rvalidCount = 0, doneCount = 0, doneWithBusrq = 0;
   logic        prevWrLow = 1'b0;
   logic [15:0] lastWrAddr = 16'h0;
   logic [7:0]  lastWrData = 8'h0;
   logic [7:0]  rdBuf [0:7];

   z80_host_master_if busIf ();

   z80_host_master #(.WAIT_TIMEOUT(8)) dut (
      .clk         (clk),
      .rst_n       (rstN),
      .cen_i       (cen),
      .cmd_valid_i (cmdValid),
      .cmd_ready_o (cmdReady),
      .cmd_we_i    (cmdWe),
      .cmd_io_i    (cmdIo),
      .cmd_addr_i  (cmdAddr),
      .cmd_len_i   (cmdLen),
      .wdata_i     (wdata),
      .wvalid_i    (wvalid),
      .wready_o    (wready),
      .rdata_o     (rdata),
      .rvalid_o    (rvalid),
      .done_o      (done),
      .err_o       (err),
      .bus         (busIf)
   );

   // 100 MHz-style clock with a CPU enable every fourth cycle.
   always #5 clk = ~clk;

   always @(posedge clk) cenDiv <= cenDiv + 2'd1;
   assign cen = (cenDiv == 2'd3);

   // ROM slave: data is the byte sum of the address halves.
   wire strobeAct = (busIf.mreqn === 1'b0) || (busIf.iorqn === 1'b0);
   assign busIf.dslave = busIf.addr[7:0] + busIf.addr[15:8];
   assign busIf.mwait  = !(strobeAct && (slaveCnt < slaveWaits));

   // Slave wait counter restarts for every strobed cycle.
   always @(posedge clk) begin
      if (!strobeAct) slaveCnt <= 0;
      else if (cen && slaveCnt < slaveWaits) slaveCnt <= slaveCnt + 1;
   end

   // Arbiter grants BUSACK ackDelay cen ticks after the request and drops it
   // on the first cen after the request goes away.
   always @(posedge clk) begin
      if (!rstN) begin
         busIf.busack <= 1'b0;
         ackCnt       <= 0;
      end else if (cen) begin
         if (busIf.busrq && !busIf.busack) begin
            if (ackCnt >= ackDelay) busIf.busack <= 1'b1;
            else ackCnt <= ackCnt + 1;
         end else if (!busIf.busrq) begin
            busIf.busack <= 1'b0;
            ackCnt       <= 0;
         end
      end
   end

   // Passive bus monitor; per-cen counts are taken on the cycle carrying cen,
   // which is the last clk of each bus state.
   always @(negedge clk) begin
      if (cen) begin
         if (busIf.wrn === 1'b0)   wrLowTicks   <= wrLowTicks + 1;
         if (busIf.rdn === 1'b0)   rdLowTicks   <= rdLowTicks + 1;
         if (busIf.mreqn === 1'b0) mreqLowTicks <= mreqLowTicks + 1;
         if (busIf.iorqn === 1'b0) iorqLowTicks <= iorqLowTicks + 1;
         if (strobeAct)            strobeLowTicks <= strobeLowTicks + 1;
         if (busIf.busrq === 1'b1 && busIf.busack === 1'b1) busTicks <= busTicks + 1;
         if (busIf.busrq === 1'b1 && busIf.busack === 1'b0) reqWaitTicks <= reqWaitTicks + 1;
      end
      if (busIf.wrn === 1'b0 && !prevWrLow) wrWindows <= wrWindows + 1;
      prevWrLow <= (busIf.wrn === 1'b0);
      if (busIf.wrn === 1'b0) begin
         lastWrAddr <= busIf.addr;
         lastWrData <= busIf.dmaster;
      end
      if (busIf.mreqn === 1'b0 && busIf.iorqn === 1'b0) ioMemBoth <= ioMemBoth + 1;
      if (busIf.rdn === 1'b0 && busIf.wrn === 1'b0)     rdWrBoth  <= rdWrBoth + 1;
      if (busIf.busack === 1'b0 && (strobeAct || busIf.rdn === 1'b0 || busIf.wrn === 1'b0))
         noAckStrobe <= noAckStrobe + 1;
      if (rvalid === 1'b1) begin
         rdBuf[rvalidCount % 8] <= rdata;
         rvalidCount <= rvalidCount + 1;
      end
      if (done === 1'b1) begin
         doneCount <= doneCount + 1;
         if (busIf.busrq !== 1'b0) doneWithBusrq <= doneWithBusrq + 1;
      end
   end

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one burst command and hold it until the block accepts it.
   task automatic applyStimulus(input logic we, input logic io, input logic [15:0] addr,
                                input logic [7:0] len, input logic [7:0] data);
      bit accepted = 0;
      @(negedge clk);
      cmdWe    = we;
      cmdIo    = io;
      cmdAddr  = addr;
      cmdLen   = len;
      wdata    = data;
      wvalid   = we;
      cmdValid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (cmdReady === 1'b1) begin
            accepted = 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("cmd_accepted", 32'(accepted), 32'd1);
      @(negedge clk);
      cmdValid = 1'b0;
   endtask

   // Wait (bounded) for the done pulse and return its err qualifier.
   task automatic waitDone(input string tag, output logic errSeen);
      bit seen = 0;
      errSeen = 1'bx;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen    = 1;
            errSeen = err;
            break;
         end
      end
      checkOutput(tag, 32'(seen), 32'd1);
      wvalid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   int b0, b1, b2, b3, bd;
   logic errSeen;

   initial begin
      rstN = 1'b0; cmdValid = 1'b0; cmdWe = 1'b0; cmdIo = 1'b0;
      cmdAddr = 16'h0; cmdLen = 8'h0; wdata = 8'h0; wvalid = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values.
      checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd0);
      checkOutput("rst_busrq", 32'(busIf.busrq), 32'd0);
      checkOutput("rst_wready", 32'(wready), 32'd0);
      checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
      checkOutput("rst_done_err", 32'({done, err}), 32'd0);
      checkOutput("rst_rdata", 32'(rdata), 32'h00);
      checkOutput("rst_addr", 32'(busIf.addr), 32'h0000);
      checkOutput("rst_dmaster", 32'(busIf.dmaster), 32'h00);
      checkOutput("rst_strobes", 32'({busIf.rdn, busIf.wrn, busIf.mreqn, busIf.iorqn}), 32'hF);
      checkOutput("rst_inta", 32'(busIf.inta), 32'd1);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("idle_cmd_ready", 32'(cmdReady), 32'd1);

      // Single memory write, no waits.
      b0 = wrWindows; b1 = wrLowTicks; b2 = mreqLowTicks; b3 = iorqLowTicks; bd = doneCount;
      applyStimulus(1'b1, 1'b0, 16'h6000, 8'd0, 8'hA5);
      waitDone("wr_done", errSeen);
      checkOutput("wr_err", 32'(errSeen), 32'd0);
      checkOutput("wr_windows", 32'(wrWindows - b0), 32'd1);
      checkOutput("wr_low_ticks", 32'(wrLowTicks - b1), 32'd1);
      checkOutput("wr_mreq_ticks", 32'(mreqLowTicks - b2), 32'd1);
      checkOutput("wr_iorq_ticks", 32'(iorqLowTicks - b3), 32'd0);
      checkOutput("wr_addr", 32'(lastWrAddr), 32'h6000);
      checkOutput("wr_data", 32'(lastWrData), 32'hA5);
      checkOutput("wr_done_count", 32'(doneCount - bd), 32'd1);

      // Four-byte memory read crossing 3FFFh/4000h: 1 grant tick + 4 x 3.
      b0 = rvalidCount; b1 = busTicks; b2 = rdLowTicks;
      applyStimulus(1'b0, 1'b0, 16'h3FFE, 8'd3, 8'h00);
      waitDone("rd_done", errSeen);
      checkOutput("rd_err", 32'(errSeen), 32'd0);
      checkOutput("rd_rvalid_count", 32'(rvalidCount - b0), 32'd4);
      checkOutput("rd_byte0", 32'(rdBuf[(b0 + 0) % 8]), 32'h3D);
      checkOutput("rd_byte1", 32'(rdBuf[(b0 + 1) % 8]), 32'h3E);
      checkOutput("rd_byte2", 32'(rdBuf[(b0 + 2) % 8]), 32'h40);
      checkOutput("rd_byte3", 32'(rdBuf[(b0 + 3) % 8]), 32'h41);
      checkOutput("rd_bus_ticks", 32'(busTicks - b1), 32'd13);
      checkOutput("rd_low_ticks", 32'(rdLowTicks - b2), 32'd4);
      checkOutput("rd_hold", 32'(rdata), 32'h41);

      // I/O write.
      b0 = iorqLowTicks; b1 = mreqLowTicks;
      applyStimulus(1'b1, 1'b1, 16'h0000, 8'd0, 8'h5A);
      waitDone("io_done", errSeen);
      checkOutput("io_err", 32'(errSeen), 32'd0);
      checkOutput("io_iorq_ticks", 32'(iorqLowTicks - b0), 32'd1);
      checkOutput("io_mreq_ticks", 32'(mreqLowTicks - b1), 32'd0);
      checkOutput("io_addr", 32'(lastWrAddr), 32'h0000);
      checkOutput("io_data", 32'(lastWrData), 32'h5A);

      // Five slave wait states: strobes held for T2 + 5 TW ticks.
      slaveWaits = 5;
      b0 = strobeLowTicks; b1 = wrLowTicks;
      applyStimulus(1'b1, 1'b0, 16'h7000, 8'd0, 8'h3C);
      waitDone("wait_done", errSeen);
      slaveWaits = 0;
      checkOutput("wait_err", 32'(errSeen), 32'd0);
      checkOutput("wait_strobe_ticks", 32'(strobeLowTicks - b0), 32'd6);
      checkOutput("wait_wr_ticks", 32'(wrLowTicks - b1), 32'd6);
      checkOutput("wait_data", 32'(lastWrData), 32'h3C);

      // Stuck mwait: abort after T2 + 8 TW ticks, no data returned.
      slaveWaits = 1000;
      b0 = strobeLowTicks; b1 = rvalidCount; b2 = rdLowTicks;
      applyStimulus(1'b0, 1'b0, 16'h8000, 8'd2, 8'h00);
      waitDone("tmo_done", errSeen);
      slaveWaits = 0;
      checkOutput("tmo_err", 32'(errSeen), 32'd1);
      checkOutput("tmo_strobe_ticks", 32'(strobeLowTicks - b0), 32'd9);
      checkOutput("tmo_rd_ticks", 32'(rdLowTicks - b2), 32'd9);
      checkOutput("tmo_rvalid", 32'(rvalidCount - b1), 32'd0);

      // Next command after an error must report clean completion; read wraps.
      b0 = rvalidCount;
      applyStimulus(1'b0, 1'b0, 16'hFFFF, 8'd1, 8'h00);
      waitDone("wrap_done", errSeen);
      checkOutput("wrap_err", 32'(errSeen), 32'd0);
      checkOutput("wrap_count", 32'(rvalidCount - b0), 32'd2);
      checkOutput("wrap_byte0", 32'(rdBuf[(b0 + 0) % 8]), 32'hFE);
      checkOutput("wrap_byte1", 32'(rdBuf[(b0 + 1) % 8]), 32'h00);

      // Grant delayed 20 cen: 21 request-only ticks, strobes high throughout.
      ackDelay = 20;
      b0 = reqWaitTicks; b1 = noAckStrobe; b2 = rvalidCount;
      applyStimulus(1'b0, 1'b0, 16'h1234, 8'd0, 8'h00);
      waitDone("ack_done", errSeen);
      ackDelay = 0;
      checkOutput("ack_err", 32'(errSeen), 32'd0);
      checkOutput("ack_wait_ticks", 32'(reqWaitTicks - b0), 32'd21);
      checkOutput("ack_strobe_noack", 32'(noAckStrobe - b1), 32'd0);
      checkOutput("ack_byte", 32'(rdBuf[b2 % 8]), 32'h46);

      // Reset during T2 of a write.
      bd = doneCount;
      applyStimulus(1'b1, 1'b0, 16'h5555, 8'd0, 8'h11);
      begin
         bit hit = 0;
         for (int i = 0; i < 400; i++) begin
            if (busIf.wrn === 1'b0) begin
               hit = 1;
               break;
            end
            @(negedge clk);
         end
         checkOutput("rst_t2_reached", 32'(hit), 32'd1);
      end
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("rst_t2_strobes", 32'({busIf.rdn, busIf.wrn, busIf.mreqn, busIf.iorqn}), 32'hF);
      checkOutput("rst_t2_busrq", 32'(busIf.busrq), 32'd0);
      wvalid = 1'b0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      checkOutput("rst_t2_no_done", 32'(doneCount - bd), 32'd0);
      checkOutput("rst_t2_idle", 32'(cmdReady), 32'd1);

      // Whole-run bus invariants.
      checkOutput("excl_mreq_iorq", 32'(ioMemBoth), 32'd0);
      checkOutput("excl_rd_wr", 32'(rdWrBoth), 32'd0);
      checkOutput("done_after_busrq", 32'(doneWithBusrq), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

   // Safety net in case a bounded wait is itself broken.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/z80_host_master.md
# z80_host_master

Host-driven Z80 bus initiator for the dkong system. It takes burst commands from an external host (ARM loader or debug UART bridge) and gains bus ownership through the CPU BUSRQ/BUSACK handshake. It then drives memory or I/O read/write cycles onto the shared slave bus exactly as the CPU would, honouring slave `mwait`. It is a second bus master alongside `fakedma` and feeds one `sysmux` master input.

## Interface
Parameters:
- `WAIT_TIMEOUT`, default 1024: maximum `cen` ticks a single cycle may sit in wait states before the burst aborts.

Ports:
- `clk`  in  1  system clock (masterclk).
- `rst_n`  in  1  reset; synchronous, active-low (already decided).
- `cen`  in  1  CPU-clock rising-edge enable; all bus state advances only on `cen`.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  block accepts a command (IDLE only).
- `cmd_we`  in  1  1 = write burst, 0 = read burst.
- `cmd_io`  in  1  1 = I/O cycles (`iorqn`), 0 = memory cycles (`mreqn`).
- `cmd_addr`  in  16  start address.
- `cmd_len`  in  8  burst length minus one (0 → 1 byte, 255 → 256 bytes).
- `wdata`  in  8  write byte.
- `wvalid`  in  1  write byte present.
- `wready`  out  1  write byte accepted this clk.
- `rdata`  out  8  read byte.
- `rvalid`  out  1  one-clk pulse, `rdata` valid; no backpressure.
- `done`  out  1  one-clk pulse at burst end.
- `err`  out  1  qualifies `done`; 1 = aborted by timeout.
- `busrq`  out  1  bus request, active-high.
- `busack`  in  1  bus grant, active-high.
- `obus`  out  Z80MasterBus  master-side bus (addr, dmaster, rdn, wrn, mreqn, iorqn, inta).
- `ibus`  in  Z80SlaveBus  shared slave return (dslave, mwait).

## Operation
- States: IDLE, REQ, WDAT, T1, T2, TW, T3, REL.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch we/io/addr/len into `cur_addr`, `remaining`.
  - Go to REQ and assert `busrq`.
- REQ: on `cen` with `busack`=1, go to WDAT if write, else T1.
- WDAT:
  - `wready`=1.
  - On `wvalid`, latch `wdata` into `obus.dmaster`.
  - Go to T1 with no `cen` needed.
- T1: `obus.addr`=`cur_addr`, all strobes high. On `cen`, go to T2.
- T2: assert `mreqn` or `iorqn` (per `cmd_io`) plus `rdn` or `wrn` (per `cmd_we`). On `cen`, go to TW if `ibus.mwait`=0, else T3.
- TW:
  - Strobes held; wait counter increments on each `cen`.
  - On `cen` with `mwait`=1, go to T3.
  - When the counter reaches `WAIT_TIMEOUT`, deassert strobes and go to REL with the error flag set.
- T3:
  - On `cen`, deassert all strobes.
  - On a read, latch `ibus.dslave` into `rdata` and pulse `rvalid`.
  - If `remaining`=0, go to REL. Otherwise `cur_addr`+1 (16-bit wrap, FFFFh→0000h), `remaining`−1, and go to WDAT or T1.
- REL:
  - Drop `busrq`.
  - Wait for `busack`=0, sampled on `cen`.
  - Pulse `done` (with `err`), clear the wait counter and error flag, go to IDLE.
- Strobe rules:
  - `iorqn` and `mreqn` are never low together.
  - `rdn` and `wrn` are never low together.
  - `obus.inta` is tied inactive (1).
- Bus outputs may drive any value while `busack`=0, because `sysmux` selects the CPU. Strobes are nevertheless held high outside T2/TW.
- `cmd_valid` outside IDLE is ignored; the host holds it until `cmd_ready`.

## Timing
- Reset values:
  - `busrq`=0, `cmd_ready`=0 during reset then 1 in IDLE, `wready`=0, `rvalid`=0, `done`=0, `err`=0, `rdata`=00h.
  - `obus.addr`=0000h, `dmaster`=00h, rdn/wrn/mreqn/iorqn=1.
- Bus cycle with no waits is 3 `cen` ticks per byte (T1, T2, T3).
- Each slave wait (`mwait`=0 sampled on `cen`) adds one `cen` tick.
- `rvalid` fires in the same clk as the T3 `cen`. `rdata` holds until the next read byte.
- `done` fires one clk after the `cen` on which `busack`=0 is seen in REL.
- Reset mid-burst takes effect on the next clk edge: strobes high, `busrq`=0, state IDLE, no `done`.
- A `busack` drop during T1–T3 is an arbiter fault and is not handled. The verification bench must not generate it.

## Test plan
- Memory write: addr 6000h, len 0, wdata A5h, slave `mwait`=1.
  - Expect exactly one `wrn`/`mreqn` low window of 1 `cen` with addr 6000h, dmaster A5h.
  - Then `busrq` falls, then `done`=1, `err`=0.
- Memory read burst: addr 3FFEh, len 3 from ROM model.
  - Expect 4 `rvalid` pulses with data from 3FFEh, 3FFFh, 4000h, 4001h.
  - Expect 12 bus `cen` ticks between the first T1 and REL.
- I/O write: `cmd_io`=1, addr 0000h, data 5Ah.
  - Expect `iorqn` low and `mreqn` high throughout.
- Wait states: tile slave holds `mwait`=0 for 5 `cen`.
  - Expect TW to last 5 ticks, the write to complete, and `err`=0.
- Timeout and wrap:
  - With `WAIT_TIMEOUT`=8 and `mwait` stuck 0, expect strobes released after 8 TW ticks, then `done`=1 with `err`=1.
  - Separately, a read at addr FFFFh with len 1 must wrap to 0000h.
- Reset and handshake:
  - Assert `rst_n`=0 during T2 of a write; expect strobes high and `busrq`=0 the next clk.
  - With `busack` delayed 20 `cen`, expect `obus` strobes high for the whole REQ wait.
